// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: default pixel width, map size and the collector FSM encoding.
package cnn_pkg;
  localparam int DATAWIDTH  = 32;
  localparam int IMAGE_SIZE = 28;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} collect_state_t;
  typedef logic [DATAWIDTH-1:0] pixel_t;
endpackage

// File: rtl/map_index_counter.sv
// Row-major pair index for an N x N map: col steps by 2 and wraps at N-2.
// The counter wraps to (0,0) after the last pair so it is ready for the next frame.
module map_index_counter #(
  parameter  int N  = 28,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);
  logic col_wrap;

  assign col_wrap = (col == CW'(N - 2));
  assign last     = col_wrap && (row == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_wrap) begin
        col <= '0;
        row <= last ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(2);
      end
    end
  end
endmodule

// File: rtl/act_map_collector_2d.sv
// Assembles a two-lane pixel stream into an N x N feature map, row-major, and flags a full frame.
// Optional sticky err output for beats presented outside COLLECT: define ACT_COLLECT_ERR_EN.
module act_map_collector_2d
  import cnn_pkg::*;
#(
  parameter  int datawidth  = DATAWIDTH,
  parameter  int image_size = IMAGE_SIZE,
  localparam int CW         = (image_size > 1) ? $clog2(image_size) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [datawidth-1:0] in_pix0,
  input  logic [datawidth-1:0] in_pix1,
  output logic [datawidth-1:0] out_map [image_size][image_size],
  output logic                 busy,
`ifdef ACT_COLLECT_ERR_EN
  output logic                 err,
`endif
  output logic                 done
);
  if ((image_size % 2) != 0) begin : g_odd_size
    $error("act_map_collector_2d: image_size must be even");
  end

  collect_state_t state, state_nxt;
  logic           accept, clear;
  logic [CW-1:0]  row, col, col_odd;
  logic           last;
  logic [1:0][datawidth-1:0] lane_pix;

  // ready is a pure state decode so upstream never sees a valid->ready path
  assign in_ready = (state == COLLECT);
  assign busy     = (state == COLLECT);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign col_odd  = col | CW'(1);
  assign lane_pix = {in_pix1, in_pix0};

  map_index_counter #(.N(image_size)) u_idx (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .advance(accept),
    .row    (row),
    .col    (col),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE:    if (start) begin state_nxt = COLLECT; clear = 1'b1; end
      COLLECT: if (accept && last) state_nxt = DONE;
      DONE:    if (start) begin state_nxt = COLLECT; clear = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < image_size; r++)
        for (int c = 0; c < image_size; c++)
          out_map[r][c] <= '0;
    end else if (accept) begin
      out_map[row][col]     <= lane_pix[0];
      out_map[row][col_odd] <= lane_pix[1];
    end
  end

`ifdef ACT_COLLECT_ERR_EN
  // a stray beat in the same cycle as start still counts as dropped, so set wins over clear
  always_ff @(posedge clk) begin
    if (rst)                                err <= 1'b0;
    else if (in_valid && state != COLLECT)  err <= 1'b1;
    else if (start && state != COLLECT)     err <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_act_map_collector_2d.sv
// Self-checking bench for act_map_collector_2d against a beat-index reference map.
module tb_act_map_collector_2d;
  localparam int DW    = 32;
  localparam int N     = 28;
  localparam int HALF  = N / 2;
  localparam int BEATS = N * N / 2;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, busy, done;
  logic [DW-1:0] in_pix0, in_pix1;
  logic [DW-1:0] out_map [N][N];
`ifdef ACT_COLLECT_ERR_EN
  logic          err;
`endif

  logic [DW-1:0] ref_map [N][N];
  int errors = 0;
  int checks = 0;
  int edges, busy_cnt, nd;
  bit done_early;

  act_map_collector_2d #(.datawidth(DW), .image_size(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pix0 (in_pix0),
    .in_pix1 (in_pix1),
    .out_map (out_map),
    .busy    (busy),
`ifdef ACT_COLLECT_ERR_EN
    .err     (err),
`endif
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int map_diff();
    int n = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (out_map[r][c] !== ref_map[r][c]) n++;
    return n;
  endfunction

  task automatic clear_ref();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        ref_map[r][c] = '0;
  endtask

  task automatic do_start(input bit with_valid);
    start    = 1'b1;
    in_valid = with_valid;
    in_pix0  = 32'hDEAD;
    in_pix1  = 32'hBEEF;
    step();
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Beat k of a frame belongs at row k/(N/2), columns 2*(k%(N/2)) and +1.
  task automatic drive_frame(input logic [DW-1:0] base, input bit gaps, input int nbeats);
    int k, cyc, r, c;
    bit v;
    k = 0; cyc = 0; busy_cnt = 0; done_early = 0;
    while (k < nbeats && cyc < 4 * BEATS + 16) begin
      v = gaps ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      r = k / HALF;
      c = 2 * (k % HALF);
      in_valid = v;
      in_pix0  = base + DW'(r * N + c);
      in_pix1  = base + DW'(r * N + c + 1);
      if (busy) busy_cnt++;
      if (done) done_early = 1;
      step();
      if (v) begin
        ref_map[r][c]     = base + DW'(r * N + c);
        ref_map[r][c + 1] = base + DW'(r * N + c + 1);
        k++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    edges = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pix0 = '0; in_pix1 = '0;
    step();
    rst = 1'b0;
    clear_ref();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    nd = map_diff();
    checks++; if (nd !== 0) begin errors++; $display("FAIL reset_map: got %0d wrong words want 0", nd); end
`ifdef ACT_COLLECT_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
`endif
  endtask

  task automatic test_full_frame();
    do_start(1'b0);
    drive_frame('0, 1'b0, BEATS);
    checks++; if (edges !== BEATS) begin errors++; $display("FAIL full_edges: got %0d want %0d", edges, BEATS); end
    checks++; if (busy_cnt !== BEATS) begin errors++; $display("FAIL full_busy_cycles: got %0d want %0d", busy_cnt, BEATS); end
    checks++; if (done_early !== 1'b0) begin errors++; $display("FAIL full_done_early: got %b want 0", done_early); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL full_idle_outputs: got busy=%b ready=%b want 0 0", busy, in_ready); end
    nd = map_diff();
    checks++; if (nd !== 0) begin errors++; $display("FAIL full_map: got %0d wrong words want 0", nd); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] base;
    base = $urandom;
    do_start(1'b0);
    drive_frame(base, 1'b1, BEATS);
    checks++; if (done_early !== 1'b0) begin errors++; $display("FAIL bp_done_early: got %b want 0", done_early); end
    checks++; if (edges !== 2 * BEATS) begin errors++; $display("FAIL bp_edges: got %0d want %0d", edges, 2 * BEATS); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done); end
    nd = map_diff();
    checks++; if (nd !== 0) begin errors++; $display("FAIL bp_map: got %0d wrong words want 0", nd); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] base;
    base = $urandom;
    do_start(1'b0);
    drive_frame(base, 1'b0, 100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_ref();
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got ready=%b busy=%b done=%b want 0 0 0", in_ready, busy, done); end
    nd = map_diff();
    checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_map: got %0d wrong words want 0", nd); end
    base = $urandom;
    do_start(1'b0);
    drive_frame(base, 1'b0, BEATS);
    checks++; if (done !== 1'b1 || edges !== BEATS) begin errors++; $display("FAIL midrst_refill_done: got done=%b edges=%0d want 1 %0d", done, edges, BEATS); end
    nd = map_diff();
    checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_refill_map: got %0d wrong words want 0", nd); end
  endtask

  task automatic test_start_with_valid();
    logic [DW-1:0] base;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_ref();
    do_start(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swv_busy: got %b want 1", busy); end
    checks++; if (out_map[0][0] !== 32'h0) begin errors++; $display("FAIL swv_not_written: got %h want 0", out_map[0][0]); end
`ifdef ACT_COLLECT_ERR_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL swv_err: got %b want 1", err); end
`endif
    base = $urandom;
    drive_frame(base, 1'b0, BEATS);
    checks++; if (out_map[0][0] !== base) begin errors++; $display("FAIL swv_first_beat: got %h want %h", out_map[0][0], base); end
    nd = map_diff();
    checks++; if (nd !== 0) begin errors++; $display("FAIL swv_map: got %0d wrong words want 0", nd); end
`ifdef ACT_COLLECT_ERR_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL swv_err_sticky: got %b want 1", err); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] base;
    base = 1000 + $urandom_range(0, 50000);
    do_start(1'b0);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got done=%b busy=%b want 0 1", done, busy); end
`ifdef ACT_COLLECT_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err_clear: got %b want 0", err); end
`endif
    drive_frame(base, 1'b0, BEATS);
    checks++; if (done !== 1'b1 || edges !== BEATS) begin errors++; $display("FAIL b2b_done: got done=%b edges=%0d want 1 %0d", done, edges, BEATS); end
    nd = map_diff();
    checks++; if (nd !== 0) begin errors++; $display("FAIL b2b_map: got %0d wrong words want 0", nd); end
  endtask

  task automatic test_overrun();
    in_valid = 1'b1;
    in_pix0  = $urandom;
    in_pix1  = $urandom;
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL ovr_state: got ready=%b done=%b want 0 1", in_ready, done); end
    nd = map_diff();
    checks++; if (nd !== 0) begin errors++; $display("FAIL ovr_map: got %0d wrong words want 0", nd); end
`ifdef ACT_COLLECT_ERR_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovr_err: got %b want 1", err); end
    repeat (3) step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovr_err_hold: got %b want 1", err); end
    do_start(1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovr_err_clear: got %b want 0", err); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_reset_mid();
    test_start_with_valid();
    test_back_to_back();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
